// File: rtl/in_reg_pkg.sv
// ---------------------------------------------------------------------------
// in_reg_pkg
//
// Purpose : shared constants and elaboration helpers for the input-register
//           bank (in_reg_sync_bank / in_reg_chan).
//
// Contents:
//   SYNC_MAX   largest supported synchroniser depth
//   FILT_MAX   largest supported debounce length
//   WIDTH_MAX  largest supported channel count
//   cnt_width  debounce counter width for a given filter length
//   params_ok  range check used to stop elaboration on bad parameters
// ---------------------------------------------------------------------------
package in_reg_pkg;

    localparam int SYNC_MAX  = 4;
    localparam int FILT_MAX  = 255;
    localparam int WIDTH_MAX = 32;

    // The counter only ever holds 0..FILT_LEN-1, so clog2(FILT_LEN) bits are
    // enough. FILT_LEN of 1 or 2 still gets one bit so the vector is legal.
    function automatic int cnt_width(input int filt_len);
        if (filt_len <= 2) begin
            return 1;
        end
        return $clog2(filt_len);
    endfunction

    function automatic bit params_ok(input int width,
                                     input int sync_stages,
                                     input int filt_len);
        return (width >= 1) && (width <= WIDTH_MAX) &&
               (sync_stages >= 1) && (sync_stages <= SYNC_MAX) &&
               (filt_len >= 1) && (filt_len <= FILT_MAX);
    endfunction

endpackage

// File: rtl/in_reg_chan.sv
// ---------------------------------------------------------------------------
// in_reg_chan
//
// Purpose : one input channel. Synchronises an asynchronous pad bit, debounces
//           it with a consecutive-sample filter, produces registered rise/fall
//           strobes from the filtered value and offers a combinational bypass.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous, active-high reset
//   i_din    raw pad input, asynchronous to i_clk
//   i_sel    1 = o_dout driven directly by i_din (bypass)
//   i_hold   freeze the filter counter and stable value
//   o_dout   i_sel ? i_din : stable
//   o_rise   one-cycle strobe in the cycle stable becomes 1
//   o_fall   one-cycle strobe in the cycle stable becomes 0
//
// Timing: a step on i_din that is captured by edge 1 and then held is
// accepted into stable by edge SYNC_STAGES+FILT_LEN (counting the capturing
// edge as edge 1); the strobe is asserted in that same cycle.
// ---------------------------------------------------------------------------
module in_reg_chan
    import in_reg_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    input  logic i_sel,
    input  logic i_hold,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic w_syn;
    logic w_diff;
    logic w_accept;

    // -----------------------------------------------------------------------
    // Synchroniser: shifts every clock, hold has no effect here so that the
    // chain always carries the current pad value when hold is released.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_BIT}};
        end else begin
            r_sync[0] <= i_din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_syn  = r_sync[SYNC_STAGES-1];
    assign w_diff = w_syn ^ r_stable;

    // The last differing sample of a full run is the one that is accepted:
    // the counter has already seen FILT_LEN-1 earlier differing samples.
    assign w_accept = !i_hold && w_diff && (r_cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // Debounce filter and strobes. Strobes are registered on the same edge
    // that updates stable, so they line up with the new o_dout value.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= RST_BIT;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= w_accept &&  w_syn;
            r_fall <= w_accept && !w_syn;
            if (!i_hold) begin
                if (!w_diff) begin
                    // Any matching sample restarts the run.
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_stable <= w_syn;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Bypass is purely combinational; the filter keeps running underneath.
    assign o_dout = i_sel ? i_din : r_stable;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/in_reg_sync_bank.sv
// ---------------------------------------------------------------------------
// in_reg_sync_bank
//
// Purpose : WIDTH independent slow-input channels between IO pads and fabric
//           logic (buttons, straps, handshake lines). Each channel is a
//           synchroniser, a debounce filter, rise/fall strobes and a bypass.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   data_in   [WIDTH] raw pad inputs, asynchronous to clk
//   sel       [WIDTH] per-channel bypass, 1 = data_out[i] follows data_in[i]
//   hold      bank-wide freeze of stable values and filter counters
//   data_out  [WIDTH] sel[i] ? data_in[i] : stable[i]
//   rise      [WIDTH] one-cycle strobe when stable[i] goes 0->1
//   fall      [WIDTH] one-cycle strobe when stable[i] goes 1->0
//
// There is no handshake: every output is meaningful in every cycle, and
// strobes are single-cycle pulses with no acknowledge.
// ---------------------------------------------------------------------------
module in_reg_sync_bank
    import in_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_LEN    = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] sel,
    input  logic             hold,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Stop elaboration rather than build a bank with unsupported geometry.
    if (!params_ok(WIDTH, SYNC_STAGES, FILT_LEN)) begin : g_param_err
        $error("in_reg_sync_bank: parameter out of range (WIDTH=%0d SYNC_STAGES=%0d FILT_LEN=%0d)",
               WIDTH, SYNC_STAGES, FILT_LEN);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        in_reg_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .RST_BIT     (RST_VAL[g])
        ) u_chan (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_din  (data_in[g]),
            .i_sel  (sel[g]),
            .i_hold (hold),
            .o_dout (data_out[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
        );
    end

endmodule
